// File: rtl/hazard_scoreboard_pkg.sv
// rtl/hazard_scoreboard_pkg.sv - shared types and constants for the hazard scoreboard
package hazard_scoreboard_pkg;

  // dest is stored zero-extended to this width; REG_AW must not exceed it
  localparam int SB_DEST_W = 8;

  localparam int FWD_NONE   = 0;
  localparam int MODE_STALL = 0;
  localparam int MODE_FWD   = 1;

  typedef struct packed {
    logic                 v;
    logic                 wb;
    logic                 ld;
    logic [SB_DEST_W-1:0] dest;
  } sb_entry_t;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// rtl/hazard_scoreboard_if.sv - ID-stage hazard bus; counters present when HAZARD_PERF_CNT_EN is defined
interface hazard_scoreboard_if #(
  parameter int REG_AW = 4,
  parameter int DEPTH  = 3,
  parameter int SEL_W  = $clog2(DEPTH + 1)
);
  logic              id_valid;
  logic [REG_AW-1:0] id_src1;
  logic [REG_AW-1:0] id_src2;
  logic              id_two_src;
  logic              id_wb_en;
  logic              id_mem_r_en;
  logic [REG_AW-1:0] id_dest;
  logic              branch_taken;
  logic              stall;
  logic [SEL_W-1:0]  fwd_sel1;
  logic [SEL_W-1:0]  fwd_sel2;
  logic [DEPTH-1:0]  inflight;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0]       stall_cnt;
  logic [15:0]       flush_cnt;

  modport master (
    output id_valid, id_src1, id_src2, id_two_src, id_wb_en, id_mem_r_en, id_dest, branch_taken,
    input  stall, fwd_sel1, fwd_sel2, inflight, stall_cnt, flush_cnt
  );
  modport slave (
    input  id_valid, id_src1, id_src2, id_two_src, id_wb_en, id_mem_r_en, id_dest, branch_taken,
    output stall, fwd_sel1, fwd_sel2, inflight, stall_cnt, flush_cnt
  );
`else
  modport master (
    output id_valid, id_src1, id_src2, id_two_src, id_wb_en, id_mem_r_en, id_dest, branch_taken,
    input  stall, fwd_sel1, fwd_sel2, inflight
  );
  modport slave (
    input  id_valid, id_src1, id_src2, id_two_src, id_wb_en, id_mem_r_en, id_dest, branch_taken,
    output stall, fwd_sel1, fwd_sel2, inflight
  );
`endif
endinterface

// File: rtl/hazard_scoreboard_sb_match_prio.sv
// rtl/hazard_scoreboard_sb_match_prio.sv - lowest-index-wins encoder for one operand's match vector
module sb_match_prio
  import hazard_scoreboard_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int SEL_W = $clog2(DEPTH + 1)
) (
  input  logic [DEPTH-1:0] match,
  output logic [SEL_W-1:0] sel,
  output logic             any
);

  // Scan from the oldest entry down so the youngest writer overwrites last
  always_comb begin
    sel = SEL_W'(FWD_NONE);
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (match[k]) sel = SEL_W'(k + 1);
    end
  end

  assign any = |match;

endmodule

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - in-flight writer tracker producing ID stall and forwarding selects
// Optional stall/flush counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int REG_AW   = 4,
  parameter int DEPTH    = 3,
  parameter int FWD_MODE = MODE_FWD,
  parameter int SEL_W    = $clog2(DEPTH + 1)
) (
  input logic               clk,
  input logic               rst,
  hazard_scoreboard_if.slave sb
);

  sb_entry_t            ent [DEPTH];
  logic [DEPTH-1:0]     m1;
  logic [DEPTH-1:0]     m2;
  logic [DEPTH-1:0]     inflight_w;
  logic [SEL_W-1:0]     sel1;
  logic [SEL_W-1:0]     sel2;
  logic                 any1;
  logic                 any2;
  logic                 stall_w;
  logic                 issue;
  logic [SB_DEST_W-1:0] src1_x;
  logic [SB_DEST_W-1:0] src2_x;
  logic [SB_DEST_W-1:0] dest_x;

  assign src1_x = SB_DEST_W'(sb.id_src1);
  assign src2_x = SB_DEST_W'(sb.id_src2);
  assign dest_x = SB_DEST_W'(sb.id_dest);

  // Only entries already in flight are compared, so an instruction never hazards on itself
  always_comb begin
    m1         = '0;
    m2         = '0;
    inflight_w = '0;
    for (int k = 0; k < DEPTH; k++) begin
      inflight_w[k] = ent[k].v & ent[k].wb;
      m1[k] = sb.id_valid & inflight_w[k] & (ent[k].dest == src1_x);
      m2[k] = sb.id_valid & sb.id_two_src & inflight_w[k] & (ent[k].dest == src2_x);
    end
  end

  sb_match_prio #(.DEPTH(DEPTH), .SEL_W(SEL_W)) u_prio1 (.match(m1), .sel(sel1), .any(any1));
  sb_match_prio #(.DEPTH(DEPTH), .SEL_W(SEL_W)) u_prio2 (.match(m2), .sel(sel2), .any(any2));

  // With forwarding only a load still in EXE cannot be bypassed
  assign stall_w = sb.id_valid & ~sb.branch_taken &
                   ((FWD_MODE == MODE_FWD) ? ((m1[0] | m2[0]) & ent[0].ld) : (any1 | any2));
  assign issue   = sb.id_valid & ~stall_w & ~sb.branch_taken;

  assign sb.stall    = stall_w;
  assign sb.fwd_sel1 = (FWD_MODE == MODE_FWD) ? sel1 : SEL_W'(FWD_NONE);
  assign sb.fwd_sel2 = (FWD_MODE == MODE_FWD) ? sel2 : SEL_W'(FWD_NONE);
  assign sb.inflight = inflight_w;

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < DEPTH; k++) ent[k] <= '0;
    end else begin
      for (int k = 1; k < DEPTH; k++) ent[k] <= ent[k-1];
      if (issue) begin
        ent[0] <= '{v: 1'b1, wb: sb.id_wb_en, ld: sb.id_mem_r_en, dest: dest_x};
      end else begin
        ent[0].v  <= 1'b0;
        ent[0].wb <= 1'b0;
        ent[0].ld <= 1'b0;
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [15:0] flush_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_w && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (sb.branch_taken && sb.id_valid && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + 16'd1;
    end
  end

  assign sb.stall_cnt = stall_cnt_q;
  assign sb.flush_cnt = flush_cnt_q;
`endif

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor to the fixed two-stage hazard check in the 5-stage core.
- Tracks in-flight register writers across DEPTH post-decode stages (EXE, MEM, WB, ...) in an internal shift array.
- From that state it generates the ID-stage stall and per-operand forwarding selects.
- Two modes: stall-only, or forwarding with load-use stall. Sits beside stage2 and the ID/EX register.

Parameters:
- REG_AW, 4: register address width.
- DEPTH, 3: number of tracked post-decode stages, 2..8. Entry 0 = EXE, entry DEPTH-1 = last write-back stage.
- FWD_MODE, 1: 0 = stall on any match; 1 = forward, stall only on load-use.
- SEL_W, $clog2(DEPTH+1): width of the forwarding selects.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-low.
- id_valid  in  1  ID holds a real instruction.
- id_src1  in  REG_AW  Rn address.
- id_src2  in  REG_AW  second source address.
- id_two_src  in  1  id_src2 is used.
- id_wb_en  in  1  ID instruction writes a register.
- id_mem_r_en  in  1  ID instruction is a load.
- id_dest  in  REG_AW  ID destination.
- branch_taken  in  1  flush: kill the instruction in ID this cycle.
- stall  out  1  freeze PC and IF/ID; bubble into ID/EX.
- fwd_sel1  out  SEL_W  0 = register file; k = forward from entry k-1.
- fwd_sel2  out  SEL_W  as fwd_sel1, for src2.
- inflight  out  DEPTH  valid&wb_en bit per entry, for debug.

Behaviour:
- State: entry[k] = {v, wb, ld, dest}, k = 0..DEPTH-1.
- Reset (rst=0 at edge): all v/wb/ld = 0, dest = 0. Outputs are combinational from state, so stall=0, fwd_sel*=0, inflight=0 from the first cycle after reset. Reset mid-operation discards every in-flight entry.
- Match m1[k] = entry[k].v & entry[k].wb & (entry[k].dest == id_src1).
- m2[k] is the same against id_src2, gated by id_two_src.
- All matches are gated by id_valid.
- FWD_MODE=0:
  - stall = id_valid & ~branch_taken & OR(m1|m2).
  - fwd_sel* = 0 always.
- FWD_MODE=1:
  - stall = id_valid & ~branch_taken & ((m1[0]|m2[0]) & entry[0].ld).
  - fwd_selN = lowest k with mN[k], plus 1, i.e. the youngest writer wins; 0 if no match.
  - fwd_sel is valid even while stall=1; the consumer ignores it during stall.
- Advance every cycle, with no global enable:
  - entry[k] <= entry[k-1] for k >= 1.
  - entry[0] <= {1, id_wb_en, id_mem_r_en, id_dest} if id_valid & ~stall & ~branch_taken.
  - Otherwise entry[0] <= bubble (v=0, wb=0, ld=0, dest unchanged).
- Latency: zero-cycle combinational outputs; one-cycle state update.
- Load-use in FWD_MODE=1 stalls exactly one cycle: the load moves to entry[1], which forwards.
- Boundaries:
  - branch_taken & stall conditions in the same cycle: flush wins, stall=0, bubble inserted.
  - An entry leaving entry[DEPTH-1] is dropped. The register file writes in the first half of the cycle, so no match is needed beyond DEPTH-1.
  - Multiple matching entries: the lowest index has priority.
  - id_dest equal to one of its own sources: no self-hazard; only existing entries are compared.
  - id_valid=0: no stall, fwd_sel=0, bubble inserted.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- Defined:
  - Adds output stall_cnt (32-bit): increments on every cycle with stall=1, saturating at 0xFFFFFFFF; cleared by rst.
  - Adds output flush_cnt (16-bit): increments on every cycle with branch_taken & id_valid, saturating; cleared by rst.
- Undefined: neither port nor counter exists; behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - typedef sb_entry_t {v, wb, ld, dest[REG_AW-1:0]}.
  - FWD_NONE = 0.
  - Mode constants MODE_STALL = 0, MODE_FWD = 1.
- One sub-module is natural: sb_match_prio. It takes the DEPTH match vector and returns the priority-encoded select plus an any-match flag, and is instantiated once per source operand.

Test Plan:
- Reset: rst=0 for 2 cycles with id_valid=1, src1=3 after prior writes -> stall=0, fwd_sel1=0, inflight=0.
- FWD_MODE=0, DEPTH=3: issue ADD R2 (wb), next ID reads R2 -> stall=1 for 3 cycles. Entries advance as bubbles; stall drops when R2 exits entry[2].
- FWD_MODE=1: ADD R2 then SUB reading src1=R2, src2=R2, two_src=1 -> stall=0, fwd_sel1=fwd_sel2=1. One cycle later, a reader of R2 gets fwd_sel=2.
- FWD_MODE=1 load-use: LDR R5 then ADD reading R5 -> stall=1 for exactly one cycle, then fwd_sel1=2 with stall=0.
- Priority: ADD R4 (older), MOV R4 (younger), then reader of R4 -> fwd_sel1=1, not 2.
- Flush: a stall condition with branch_taken=1 the same cycle -> stall=0 and entry[0].v=0 next cycle. With HAZARD_PERF_CNT_EN defined: flush_cnt increments by 1 and stall_cnt is unchanged.
